ifu_fetch_ctrl: RTL and testbench

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_fetch_ctrl_pkg.sv | 19 +
 rtl/ifu_fetch_fifo.sv | 64 ++++++
 rtl/ifu_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared core definitions for the instruction fetch unit.
// Holds the default widths, the fetch FSM state encoding and a small alignment helper.
package ifu_fetch_ctrl_pkg;

  localparam int PC_WIDTH_DEF       = 32;
  localparam int INST_WIDTH_DEF     = 32;
  localparam int IMEM_DEPTH_BIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Two-entry {pc, inst} buffer between the instruction memory and decode.
// Flush empties it in one cycle; a push and a pop may happen in the same cycle.
module ifu_fetch_fifo #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [PC_WIDTH-1:0]   i_push_pc,
  input  logic [INST_WIDTH-1:0] i_push_inst,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [PC_WIDTH-1:0]   o_head_pc,
  output logic [INST_WIDTH-1:0] o_head_inst
);

  logic [PC_WIDTH-1:0]   r_pc   [2];
  logic [INST_WIDTH-1:0] r_inst [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full      = (r_count == 2'd2);
  assign o_empty     = (r_count == 2'd0);
  assign o_head_pc   = r_pc[r_rd_ptr];
  assign o_head_inst = r_inst[r_rd_ptr];

  // When full, a push is only legal if the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_pc[r_wr_ptr]   <= i_push_pc;
        r_inst[r_wr_ptr] <= i_push_inst;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, IMem issue, 2-entry fetch buffer to decode.
// Handshake: an instruction transfers on a cycle where ifu_valid & idu_ready; ifu_* hold while stalled.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH       = PC_WIDTH_DEF,
  parameter int INST_WIDTH     = INST_WIDTH_DEF,
  parameter int IMEM_DEPTH_BIT = IMEM_DEPTH_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_pulse,
  input  logic [PC_WIDTH-1:0]       start_pc,
  input  logic                      cfg_halt_unalign,
  input  logic                      bru_flush,
  input  logic [PC_WIDTH-1:0]       bru_redir_pc,
  input  logic                      idu_ready,
  output logic                      imem_cen,
  output logic [IMEM_DEPTH_BIT-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0]     imem_rd_data,
  output logic                      ifu_valid,
  output logic [PC_WIDTH-1:0]       ifu_pc,
  output logic [INST_WIDTH-1:0]     ifu_inst,
  output logic                      core_running,
  output logic                      exc_unalign,
  output logic [PC_WIDTH-1:0]       exc_pc,
  output fetch_state_e              dbg_state
);

  fetch_state_e          r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic                  r_inflight;
  logic [PC_WIDTH-1:0]   r_inflight_pc;
  logic                  r_exc;
  logic [PC_WIDTH-1:0]   r_exc_pc;

  logic                  w_run;
  logic                  w_kill;
  logic                  w_misalign;
  logic [PC_WIDTH-1:0]   w_pc_aligned;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_room;
  logic                  w_try;
  logic                  w_halt_req;
  logic                  w_issue;
  logic                  w_exc;

  assign w_run        = (r_state == ST_RUN);
  assign w_kill       = start_pulse | (bru_flush & w_run);
  assign w_misalign   = is_misaligned(r_pc[1:0]);
  assign w_pc_aligned = {r_pc[PC_WIDTH-1:2], 2'b00};
  assign w_pc_next    = w_pc_aligned + PC_WIDTH'(4);

  assign ifu_valid = ~w_empty;
  assign w_pop     = ifu_valid & idu_ready;
  // The response of last cycle's issue is killed by a same-cycle flush or start.
  assign w_push    = r_inflight & ~w_kill;

  // Issue only if buffered (after this cycle's pop) plus in-flight stays below two.
  assign w_room = r_inflight ? (w_empty | (w_pop & ~w_full))
                             : (~w_full | w_pop);

  assign w_try      = w_run & ~w_kill & ~rst;
  assign w_halt_req = w_try & w_misalign & cfg_halt_unalign;
  assign w_issue    = w_try & w_room & ~(w_misalign & cfg_halt_unalign);
  assign w_exc      = w_halt_req | (w_issue & w_misalign);

  assign imem_cen     = w_issue;
  assign imem_addr    = r_pc[IMEM_DEPTH_BIT+1:2];
  assign core_running = w_run;
  assign exc_unalign  = r_exc;
  assign exc_pc       = r_exc_pc;
  assign dbg_state    = r_state;

  ifu_fetch_fifo #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_pc   (r_inflight_pc),
    .i_push_inst (imem_rd_data),
    .i_pop       (w_pop),
    .i_flush     (w_kill),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_pc   (ifu_pc),
    .o_head_inst (ifu_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_exc         <= 1'b0;
      r_exc_pc      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_pulse) r_state <= ST_RUN;
        ST_RUN:  if (w_halt_req)  r_state <= ST_HALT;
        ST_HALT: if (start_pulse) r_state <= ST_RUN;
        default: r_state <= ST_IDLE;
      endcase

      if (start_pulse) begin
        r_pc <= start_pc;
      end else if (bru_flush & w_run) begin
        r_pc <= bru_redir_pc;
      end else if (w_issue) begin
        r_pc <= w_pc_next;
      end

      r_inflight    <= w_issue;
      r_inflight_pc <= w_pc_aligned;

      r_exc <= w_exc;
      if (w_exc) begin
        r_exc_pc <= r_pc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: per-cycle vector table for boot and backpressure,
// followed by hand-written flush, collision, misalign, wrap and reset sequences.
module tb_ifu_fetch_ctrl;
  import ifu_fetch_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_pulse;
  logic [31:0] start_pc;
  logic        cfg_halt_unalign;
  logic        bru_flush;
  logic [31:0] bru_redir_pc;
  logic        idu_ready;
  logic        imem_cen;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rd_data;
  logic        ifu_valid;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        core_running;
  logic        exc_unalign;
  logic [31:0] exc_pc;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [256];

  ifu_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start_pulse      (start_pulse),
    .start_pc         (start_pc),
    .cfg_halt_unalign (cfg_halt_unalign),
    .bru_flush        (bru_flush),
    .bru_redir_pc     (bru_redir_pc),
    .idu_ready        (idu_ready),
    .imem_cen         (imem_cen),
    .imem_addr        (imem_addr),
    .imem_rd_data     (imem_rd_data),
    .ifu_valid        (ifu_valid),
    .ifu_pc           (ifu_pc),
    .ifu_inst         (ifu_inst),
    .core_running     (core_running),
    .exc_unalign      (exc_unalign),
    .exc_pc           (exc_pc),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hC0DE, 8'h5A, a};
  endfunction

  always @(posedge clk) begin
    if (imem_cen) imem_rd_data <= mem[imem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic st, input logic [31:0] sp,
                      input logic fl, input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    start_pulse  = st;
    start_pc     = sp;
    bru_flush    = fl;
    bru_redir_pc = rp;
    idu_ready    = rdy;
    #1;
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance with idu_ready=1 until ifu_valid (bounded); the first one seen must be exp_pc.
  task automatic expect_first_valid(input string nm, input logic [31:0] exp_pc);
    int k;
    k = 0;
    while (!ifu_valid && k < 8) begin
      idle(1'b1);
      k++;
    end
    chk({nm, "_seen"}, {63'd0, ifu_valid}, 64'd1);
    if (ifu_valid) begin
      chk({nm, "_pc"},   {32'd0, ifu_pc},   {32'd0, exp_pc});
      chk({nm, "_inst"}, {32'd0, ifu_inst}, {32'd0, mem_word(exp_pc[9:2])});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start;
    logic [31:0] spc;
    logic        ready;
    logic        e_cen;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_run;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic st, input logic [31:0] sp, input logic rdy,
                              input logic cen, input logic [7:0] a,
                              input logic v, input logic [31:0] p, input logic run);
    vec_t t;
    t.start = st; t.spc = sp; t.ready = rdy;
    t.e_cen = cen; t.e_addr = a; t.e_valid = v; t.e_pc = p; t.e_run = run;
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mem_word(8'(i));
    imem_rd_data     = 32'h0;
    rst              = 1'b1;
    cfg_halt_unalign = 1'b0;
    start_pulse = 1'b0; start_pc = 32'h0; bru_flush = 1'b0; bru_redir_pc = 32'h0; idu_ready = 1'b1;

    // boot at 0x8, then five cycles of backpressure, then resume
    vecs[0]  = mk(1, 32'h8, 1, 0, 8'd0,  0, 32'h00, 0);
    vecs[1]  = mk(0, 32'h0, 1, 1, 8'd2,  0, 32'h00, 1);
    vecs[2]  = mk(0, 32'h0, 1, 1, 8'd3,  0, 32'h00, 1);
    vecs[3]  = mk(0, 32'h0, 1, 1, 8'd4,  1, 32'h08, 1);
    vecs[4]  = mk(0, 32'h0, 1, 1, 8'd5,  1, 32'h0C, 1);
    vecs[5]  = mk(0, 32'h0, 1, 1, 8'd6,  1, 32'h10, 1);
    vecs[6]  = mk(0, 32'h0, 0, 0, 8'd0,  1, 32'h14, 1);
    vecs[7]  = mk(0, 32'h0, 0, 0, 8'd0,  1, 32'h14, 1);
    vecs[8]  = mk(0, 32'h0, 0, 0, 8'd0,  1, 32'h14, 1);
    vecs[9]  = mk(0, 32'h0, 0, 0, 8'd0,  1, 32'h14, 1);
    vecs[10] = mk(0, 32'h0, 0, 0, 8'd0,  1, 32'h14, 1);
    vecs[11] = mk(0, 32'h0, 1, 1, 8'd7,  1, 32'h14, 1);
    vecs[12] = mk(0, 32'h0, 1, 1, 8'd8,  1, 32'h18, 1);
    vecs[13] = mk(0, 32'h0, 1, 1, 8'd9,  1, 32'h1C, 1);
    vecs[14] = mk(0, 32'h0, 1, 1, 8'd10, 1, 32'h20, 1);

    // ---- reset state ----
    idle(1'b1);
    idle(1'b1);
    chk("rst_valid",   {63'd0, ifu_valid},    64'd0);
    chk("rst_cen",     {63'd0, imem_cen},     64'd0);
    chk("rst_running", {63'd0, core_running}, 64'd0);
    chk("rst_exc",     {63'd0, exc_unalign},  64'd0);
    chk("rst_pc",      {32'd0, ifu_pc},       64'd0);
    chk("rst_inst",    {32'd0, ifu_inst},     64'd0);
    chk("rst_exc_pc",  {32'd0, exc_pc},       64'd0);
    chk("rst_state",   {62'd0, dbg_state},    {62'd0, ST_IDLE});
    rst = 1'b0;

    // ---- boot + backpressure table ----
    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].start, vecs[i].spc, 1'b0, 32'h0, vecs[i].ready);
      chk($sformatf("v%0d_cen", i),   {63'd0, imem_cen},     {63'd0, vecs[i].e_cen});
      chk($sformatf("v%0d_valid", i), {63'd0, ifu_valid},    {63'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_run", i),   {63'd0, core_running}, {63'd0, vecs[i].e_run});
      if (vecs[i].e_cen)
        chk($sformatf("v%0d_addr", i), {56'd0, imem_addr}, {56'd0, vecs[i].e_addr});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i),   {32'd0, ifu_pc},   {32'd0, vecs[i].e_pc});
        chk($sformatf("v%0d_inst", i), {32'd0, ifu_inst}, {32'd0, mem_word(vecs[i].e_pc[9:2])});
      end
    end

    // ---- flush while the buffer is full ----
    idle(1'b0);
    idle(1'b0);
    chk("fl_full_cen",  {63'd0, imem_cen}, 64'd0);
    chk("fl_hold_pc",   {32'd0, ifu_pc},   64'h24);
    tick(1'b0, 32'h0, 1'b1, 32'h104, 1'b0);
    chk("fl_kill_cen",  {63'd0, imem_cen}, 64'd0);
    idle(1'b1);
    chk("fl_next_valid", {63'd0, ifu_valid}, 64'd0);
    chk("fl_next_addr",  {56'd0, imem_addr}, 64'h41);
    expect_first_valid("fl_first", 32'h104);
    idle(1'b1);
    chk("fl_second_pc", {32'd0, ifu_pc}, 64'h108);

    // ---- start and flush in the same cycle ----
    tick(1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    idle(1'b1);
    chk("col_next_valid", {63'd0, ifu_valid}, 64'd0);
    expect_first_valid("col_first", 32'h40);
    idle(1'b1);
    chk("col_second_pc", {32'd0, ifu_pc}, 64'h44);

    // ---- misaligned redirect, force-align ----
    tick(1'b0, 32'h0, 1'b1, 32'h41, 1'b1);
    idle(1'b1);
    chk("mis0_cen",  {63'd0, imem_cen},  64'd1);
    chk("mis0_addr", {56'd0, imem_addr}, 64'h10);
    idle(1'b1);
    chk("mis0_exc",    {63'd0, exc_unalign}, 64'd1);
    chk("mis0_exc_pc", {32'd0, exc_pc},      64'h41);
    expect_first_valid("mis0_first", 32'h40);
    chk("mis0_exc_drop", {63'd0, exc_unalign}, 64'd0);
    idle(1'b1);
    chk("mis0_second_pc", {32'd0, ifu_pc}, 64'h44);

    // ---- misaligned redirect, halt ----
    cfg_halt_unalign = 1'b1;
    tick(1'b0, 32'h0, 1'b1, 32'h41, 1'b1);
    idle(1'b1);
    chk("mis1_cen", {63'd0, imem_cen}, 64'd0);
    idle(1'b1);
    chk("mis1_exc",     {63'd0, exc_unalign},  64'd1);
    chk("mis1_exc_pc",  {32'd0, exc_pc},       64'h41);
    chk("mis1_running", {63'd0, core_running}, 64'd0);
    chk("mis1_state",   {62'd0, dbg_state},    {62'd0, ST_HALT});
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk($sformatf("halt%0d_cen", i),   {63'd0, imem_cen},    64'd0);
      chk($sformatf("halt%0d_valid", i), {63'd0, ifu_valid},   64'd0);
      chk($sformatf("halt%0d_exc", i),   {63'd0, exc_unalign}, 64'd0);
    end
    // a flush in HALT must not restart fetch
    tick(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    idle(1'b1);
    chk("halt_flush_cen", {63'd0, imem_cen},  64'd0);
    chk("halt_flush_st",  {62'd0, dbg_state}, {62'd0, ST_HALT});

    // ---- restart from HALT near the end of IMem: address wrap ----
    cfg_halt_unalign = 1'b0;
    tick(1'b1, 32'h3F8, 1'b0, 32'h0, 1'b1);
    idle(1'b1);
    chk("wrap_a0", {56'd0, imem_addr}, 64'hFE);
    idle(1'b1);
    chk("wrap_a1", {56'd0, imem_addr}, 64'hFF);
    idle(1'b1);
    chk("wrap_a2_cen", {63'd0, imem_cen},  64'd1);
    chk("wrap_a2",     {56'd0, imem_addr}, 64'h00);
    chk("wrap_p0",     {32'd0, ifu_pc},    64'h3F8);
    idle(1'b1);
    chk("wrap_p1", {32'd0, ifu_pc}, 64'h3FC);
    idle(1'b1);
    chk("wrap_p2",      {32'd0, ifu_pc},   64'h400);
    chk("wrap_p2_inst", {32'd0, ifu_inst}, {32'd0, mem_word(8'h00)});

    // ---- reset mid-stream ----
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    chk("mrst_valid",   {63'd0, ifu_valid},    64'd0);
    chk("mrst_cen",     {63'd0, imem_cen},     64'd0);
    chk("mrst_running", {63'd0, core_running}, 64'd0);
    chk("mrst_pc",      {32'd0, ifu_pc},       64'd0);
    chk("mrst_inst",    {32'd0, ifu_inst},     64'd0);
    chk("mrst_exc_pc",  {32'd0, exc_pc},       64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk($sformatf("mrst%0d_valid", i), {63'd0, ifu_valid}, 64'd0);
      chk($sformatf("mrst%0d_cen", i),   {63'd0, imem_cen},  64'd0);
    end
    tick(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    expect_first_valid("reboot_first", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
